atm_keypad_entry: RTL

- Front-end for the ATM controller: scans a 4x4 matrix keypad, debounces it and decodes keys.
- PIN mode: produces the controller's `digito`/`add_digit`/`digito_stb` strobes.
- Amount mode: accumulates decimal digits into a 32-bit binary `monto`, delivered with a `monto_stb` pulse.
- Sits directly upstream of the ATM controller; all outputs are registered.

---
 rtl/atm_keypad_pkg.sv | 55 +++++
 rtl/atm_keypad_entry_if.sv | 26 ++
 rtl/atm_key_scanner.sv | 139 +++++++++++++
 rtl/atm_keypad_entry.sv | 114 +++++++++++
 4 files changed

// File: rtl/atm_keypad_pkg.sv
// Shared key codes, debounce/scan encodings and keypad lookup for the ATM keypad front-end.
package atm_keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned AMT_W = 32;

  localparam logic [KEY_W-1:0] K_0    = 4'd0;
  localparam logic [KEY_W-1:0] K_1    = 4'd1;
  localparam logic [KEY_W-1:0] K_2    = 4'd2;
  localparam logic [KEY_W-1:0] K_3    = 4'd3;
  localparam logic [KEY_W-1:0] K_4    = 4'd4;
  localparam logic [KEY_W-1:0] K_5    = 4'd5;
  localparam logic [KEY_W-1:0] K_6    = 4'd6;
  localparam logic [KEY_W-1:0] K_7    = 4'd7;
  localparam logic [KEY_W-1:0] K_8    = 4'd8;
  localparam logic [KEY_W-1:0] K_9    = 4'd9;
  localparam logic [KEY_W-1:0] K_A    = 4'd10;
  localparam logic [KEY_W-1:0] K_B    = 4'd11;
  localparam logic [KEY_W-1:0] K_C    = 4'd12;
  localparam logic [KEY_W-1:0] K_D    = 4'd13;
  localparam logic [KEY_W-1:0] K_STAR = 4'd14;
  localparam logic [KEY_W-1:0] K_HASH = 4'd15;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} db_state_e;
  typedef enum logic [1:0] {NONE, ONE, MULTI} scan_res_e;

  // Physical (row, col) position to key code.
  function automatic logic [KEY_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [KEY_W-1:0] code;
    case ({row, col})
      4'h0:    code = K_1;
      4'h1:    code = K_2;
      4'h2:    code = K_3;
      4'h3:    code = K_A;
      4'h4:    code = K_4;
      4'h5:    code = K_5;
      4'h6:    code = K_6;
      4'h7:    code = K_B;
      4'h8:    code = K_7;
      4'h9:    code = K_8;
      4'hA:    code = K_9;
      4'hB:    code = K_C;
      4'hC:    code = K_STAR;
      4'hD:    code = K_0;
      4'hE:    code = K_HASH;
      default: code = K_D;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return code <= K_9;
  endfunction

endpackage

// File: rtl/atm_keypad_entry_if.sv
// Keypad matrix and ATM-controller-facing signals of the keypad entry block.
interface atm_keypad_entry_if;
  import atm_keypad_pkg::*;

  logic [3:0]       row_n;
  logic [3:0]       col_n;
  logic             amount_mode;
  logic [KEY_W-1:0] digito;
  logic             add_digit;
  logic             digito_stb;
  logic [AMT_W-1:0] monto;
  logic             monto_stb;
  logic             overflow_err;
  logic             key_held;

  modport master (
    output row_n, digito, add_digit, digito_stb, monto, monto_stb, overflow_err, key_held,
    input  col_n, amount_mode
  );

  modport slave (
    input  row_n, digito, add_digit, digito_stb, monto, monto_stb, overflow_err, key_held,
    output col_n, amount_mode
  );

endinterface

// File: rtl/atm_key_scanner.sv
// Row scanner, per-scan classification and press/release debouncer for a 4x4 keypad.
module atm_key_scanner
  import atm_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       row_n,
  input  logic [3:0]       col_n,
  output logic             key_event,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_SCANS + 1) < 3) ? 3 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [1:0]       acc_cnt;
  logic [KEY_W-1:0] acc_code;
  db_state_e        state;
  logic [KEY_W-1:0] cand;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       cols;
  logic [2:0]       pop;
  logic [1:0]       col_idx;
  logic [KEY_W-1:0] row_code;
  logic [2:0]       sum;
  logic [1:0]       tot_cnt;
  logic [KEY_W-1:0] tot_code;
  scan_res_e        res;
  logic             sample;
  logic             scan_done;
  logic             cnt_hit;

  // Fold the current row's sample into the running scan; tot_* is the view including this row.
  always_comb begin
    cols     = ~col_n;
    pop      = 3'(cols[0]) + 3'(cols[1]) + 3'(cols[2]) + 3'(cols[3]);
    col_idx  = 2'd3;
    if (cols[0])      col_idx = 2'd0;
    else if (cols[1]) col_idx = 2'd1;
    else if (cols[2]) col_idx = 2'd2;
    row_code  = key_lookup(row_idx, col_idx);
    sum       = 3'(acc_cnt) + pop;
    tot_cnt   = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code  = (pop == 3'd1) ? row_code : acc_code;
    res       = (tot_cnt == 2'd0) ? NONE : ((tot_cnt == 2'd1) ? ONE : MULTI);
    sample    = (div == DIV_LAST);
    scan_done = sample && (row_idx == 2'd3);
    cnt_hit   = (cnt + CNT_W'(1)) >= CNT_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      acc_cnt   <= 2'd0;
      acc_code  <= '0;
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_event <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_event <= 1'b0;
      key_held  <= (state == HELD) || (state == RELEASE);

      if (sample) begin
        div      <= '0;
        row_idx  <= row_idx + 2'd1;
        row_n    <= {row_n[2:0], row_n[3]};
        acc_cnt  <= scan_done ? 2'd0 : tot_cnt;
        acc_code <= scan_done ? '0 : tot_code;
      end else begin
        div <= div + DIV_W'(1);
      end

      // Debounce advances once per completed scan.
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (res == ONE) begin
              cand <= tot_code;
              cnt  <= CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state     <= HELD;
                key_event <= 1'b1;
                key_code  <= tot_code;
              end else begin
                state <= PRESS;
              end
            end
          end
          PRESS: begin
            if (res == ONE && tot_code == cand) begin
              if (cnt_hit) begin
                state     <= HELD;
                key_event <= 1'b1;
                key_code  <= cand;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (res == ONE) begin
              cand <= tot_code;
              cnt  <= CNT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (res == NONE) begin
              cnt   <= CNT_W'(1);
              state <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
            end
          end
          RELEASE: begin
            if (res == NONE) begin
              if (cnt_hit) state <= IDLE;
              else         cnt   <= cnt + CNT_W'(1);
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: PIN digit strobes and decimal amount accumulation.
module atm_keypad_entry
  import atm_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned MAX_AMOUNT     = 99999999
) (
  input  logic                clk,
  input  logic                rst,
  atm_keypad_entry_if.master  bus
);

  localparam int unsigned EXT_W = AMT_W + 4;
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_AMOUNT);

  logic             key_event;
  logic [KEY_W-1:0] key_code;
  logic             key_held;
  logic [3:0]       row_n;

  logic [KEY_W-1:0] digito;
  logic             add_digit;
  logic             digito_stb;
  logic [AMT_W-1:0] monto;
  logic             monto_stb;
  logic             overflow_err;
  logic             have_digit;
  logic             mode_q;

  logic             cleared;
  logic [AMT_W-1:0] base_monto;
  logic             base_flag;
  logic [EXT_W-1:0] next_amt;
  logic             fits;

  atm_key_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (bus.col_n),
    .key_event (key_event),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  assign bus.row_n        = row_n;
  assign bus.digito       = digito;
  assign bus.add_digit    = add_digit;
  assign bus.digito_stb   = digito_stb;
  assign bus.monto        = monto;
  assign bus.monto_stb    = monto_stb;
  assign bus.overflow_err = overflow_err;
  assign bus.key_held     = key_held;

  // Accumulator as seen by this cycle's event: cleared after a delivery, on a mode edge, or in PIN mode.
  always_comb begin
    cleared    = monto_stb || (bus.amount_mode != mode_q) || !bus.amount_mode;
    base_monto = cleared ? '0 : monto;
    base_flag  = cleared ? 1'b0 : have_digit;
    next_amt   = (EXT_W'(base_monto) * EXT_W'(10)) + EXT_W'(key_code);
    fits       = (next_amt <= MAX_EXT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digito       <= '0;
      add_digit    <= 1'b0;
      digito_stb   <= 1'b0;
      monto        <= '0;
      monto_stb    <= 1'b0;
      overflow_err <= 1'b0;
      have_digit   <= 1'b0;
      mode_q       <= bus.amount_mode;
    end else begin
      add_digit    <= 1'b0;
      digito_stb   <= 1'b0;
      monto_stb    <= 1'b0;
      overflow_err <= 1'b0;
      mode_q       <= bus.amount_mode;
      monto        <= base_monto;
      have_digit   <= base_flag;

      if (key_event) begin
        if (!bus.amount_mode) begin
          if (is_digit(key_code)) begin
            digito    <= key_code;
            add_digit <= 1'b1;
          end else if (key_code == K_HASH) begin
            digito_stb <= 1'b1;
          end
        end else begin
          if (is_digit(key_code)) begin
            if (fits) begin
              monto      <= next_amt[AMT_W-1:0];
              have_digit <= 1'b1;
            end else begin
              overflow_err <= 1'b1;
            end
          end else if (key_code == K_STAR) begin
            monto      <= '0;
            have_digit <= 1'b0;
          end else if (key_code == K_HASH && base_flag) begin
            monto_stb <= 1'b1;
          end
        end
      end
    end
  end

endmodule
